ps2_key_event: RTL and testbench
================================

// Module: ps2_key_event
// PURPOSE
//  Sits between the PS/2 byte receiver and the keyboard-matrix encoder. Consumes raw scan-code
//  bytes (code/strobe/err), folds E0/F0/E1 prefix sequences into single key events
//  {code, extended, release, pause}, filters keyboard housekeeping bytes and fake shifts, and
//  buffers events in a small FIFO with a valid/ready handshake for the matrix stage.
// PARAMETERS
//  DEPTH           8        FIFO entries; power of 2, >=2
//  TIMEOUT_CYC     500000   clk cycles a prefix may stay pending before being discarded
//  DROP_FAKE_SHIFT 1        1: discard extended 0x12/0x59 events (E0 12, E0 F0 59, ...)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  code_in      in   8   scan-code byte from receiver, valid when code_strobe=1
//  code_strobe  in   1   one-cycle pulse: code_in holds a good byte
//  code_err     in   1   one-cycle pulse: framing/parity error on the line
//  ev_valid     out  1   FIFO head holds an event
//  ev_ready     in   1   consumer accepts head this cycle (pop when ev_valid & ev_ready)
//  ev_code      out  8   event scan code (0x00 for pause)
//  ev_extended  out  1   code was E0-prefixed
//  ev_release   out  1   code was F0-prefixed (break)
//  ev_pause     out  1   complete Pause/Break sequence
//  seq_err      out  1   one-cycle pulse: sequence aborted (code_err, timeout, bad prefix)
//  overflow     out  1   sticky: event dropped because FIFO full; cleared only by reset
//  fifo_level   out  $clog2(DEPTH)+1  entries currently stored
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, ev_valid=0, all ev_* 0, seq_err=0, overflow=0, timer 0.
//  Decoder FSM, advanced only on code_strobe or code_err; code_err wins if both high.
//   IDLE   : E0->GOT_E0; F0->GOT_F0; E1->PAUSE(cnt=1); else emit {code,0,0}.
//   GOT_E0 : F0->GOT_E0F0; E0->stay; E1->PAUSE(cnt=1); else emit {code,ext=1}, IDLE.
//   GOT_F0 : emit {code,rel=1}, IDLE; E0/E1/F0 -> seq_err, then treated as from IDLE.
//   GOT_E0F0: emit {code,ext=1,rel=1}, IDLE; E0/E1/F0 -> seq_err, treated as from IDLE.
//   PAUSE  : every byte increments cnt, contents not checked; at 8th byte of the sequence
//            (E1 14 77 E1 F0 14 F0 77) emit {0x00,pause=1}, IDLE. No release event exists.
//  Housekeeping bytes AA FA EE FE 00 FF: in any state except PAUSE -> discarded, state IDLE;
//   00/FF (keyboard overrun) also pulse seq_err. Inside PAUSE they count as ordinary bytes.
//  DROP_FAKE_SHIFT=1: extended events with code 0x12 or 0x59 are not written.
//  code_err in any state: state IDLE, no event, seq_err pulse.
//  Timeout: timer clears on every strobe/err and while IDLE; state!=IDLE and timer reaches
//   TIMEOUT_CYC-1 -> IDLE, seq_err pulse; partial sequence discarded.
//  Latency: byte strobed in cycle N -> event stored end of N, ev_valid/ev_* visible in N+1.
//  FIFO: first-word-fall-through; ev_* reflect head whenever ev_valid=1, stable while not popped;
//   ev_* are don't-care (driven 0) when empty. Write when full and no pop: event dropped,
//   overflow set. Write when full with pop same cycle: accepted, level unchanged.
//   Pop when empty: ignored. Write+pop same cycle at any level: level unchanged.
//  Reset mid-sequence or with FIFO non-empty: everything discarded, no event emitted after.
// STRUCTURE
//  Shared include ps2_defs.vh: PS2_E0/F0/E1, housekeeping byte constants, event field
//   positions (EV_CODE=[7:0], EV_EXT=8, EV_REL=9, EV_PAUSE=10, EV_W=11).
//  One sub-module: ps2_event_fifo (sync FWFT FIFO, params WIDTH/DEPTH, push/pop/full/empty/level).
//  Decoder FSM, pause counter and timeout counter stay in ps2_key_event.
// TESTING
//  1C; F0 1C; E0 75; E0 F0 75 (ready=1) -> {1C,0,0},{1C,rel},{75,ext},{75,ext,rel}, each valid
//   the cycle after its final strobe; ready=0 holds head stable.
//  E1 14 77 E1 F0 14 F0 77 -> exactly one event {00,pause=1}; no event for any other byte.
//  E0 then code_err, then 6B -> seq_err pulse, single event {6B,0,0}; E0 then idle TIMEOUT_CYC
//   cycles -> seq_err, next 74 -> {74,0,0}.
//  E0 12, E0 F0 59, FA, AA -> no events; 00 -> no event, seq_err pulse.
//  ready=0, DEPTH=8, 9 makes 15..1D -> level 8, overflow=1, drain yields 15..1C in order;
//   with full FIFO push+pop same cycle -> level stays 8, no overflow change.
//  reset asserted after E1 14 77 then rest of sequence -> no pause event, all outputs 0.

Source files
------------

// File: rtl/ps2_key_event_pkg.sv
// Shared constants, event layout and decoder state type for the PS/2 key-event stage.
// The event struct is packed so that code, ext, rel and pause sit at bits [7:0], 8, 9 and 10.
package ps2_key_event_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    localparam logic [7:0] HK_AA = 8'hAA;
    localparam logic [7:0] HK_FA = 8'hFA;
    localparam logic [7:0] HK_EE = 8'hEE;
    localparam logic [7:0] HK_FE = 8'hFE;
    localparam logic [7:0] HK_00 = 8'h00;
    localparam logic [7:0] HK_FF = 8'hFF;

    localparam logic [7:0] FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] FAKE_RSHIFT = 8'h59;

    localparam int EV_EXT   = 8;
    localparam int EV_REL   = 9;
    localparam int EV_PAUSE = 10;
    localparam int EV_W     = 11;

    localparam logic [2:0] PAUSE_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } dec_state_t;

    typedef struct packed {
        logic       pause;
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } key_ev_t;

    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == HK_AA) || (b == HK_FA) || (b == HK_EE) ||
               (b == HK_FE) || (b == HK_00) || (b == HK_FF);
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == HK_00) || (b == HK_FF);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_E0) || (b == PS2_F0) || (b == PS2_E1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event.sv
// Folds PS/2 scan-code prefix sequences (E0/F0/E1) into single key events
// and queues them for the keyboard-matrix stage through a valid/ready FIFO.
module ps2_key_event
    import ps2_key_event_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int TIMEOUT_CYC     = 500000,
    parameter bit DROP_FAKE_SHIFT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             code_in,
    input  logic                   code_strobe,
    input  logic                   code_err,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [7:0]             ev_code,
    output logic                   ev_extended,
    output logic                   ev_release,
    output logic                   ev_pause,
    output logic                   seq_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    dec_state_t    state;
    dec_state_t    state_n;
    logic [2:0]    cnt;
    logic [2:0]    cnt_n;
    logic [TW-1:0] timer;
    logic          err_n;
    logic          emit;
    key_ev_t       ev_n;
    logic          restart;
    logic          fake;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EV_W-1:0] head;
    key_ev_t       head_ev;

    // Bad prefix after F0 is flagged, then the byte is re-decoded as from IDLE.
    assign restart = (state == S_IDLE) ||
                     (((state == S_F0) || (state == S_E0F0)) && is_prefix(code_in));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = 1'b0;
        emit    = 1'b0;
        ev_n    = '0;
        if (code_err) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            err_n   = 1'b1;
        end else if (code_strobe) begin
            if (state == S_PAUSE) begin
                if (cnt == PAUSE_LAST) begin
                    emit       = 1'b1;
                    ev_n.pause = 1'b1;
                    state_n    = S_IDLE;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end else if (is_housekeeping(code_in)) begin
                state_n = S_IDLE;
                err_n   = is_overrun(code_in);
            end else if (restart) begin
                err_n = (state != S_IDLE);
                unique case (1'b1)
                    code_in == PS2_E0: state_n = S_E0;
                    code_in == PS2_F0: state_n = S_F0;
                    code_in == PS2_E1: begin
                        state_n = S_PAUSE;
                        cnt_n   = 3'd1;
                    end
                    default: begin
                        emit      = 1'b1;
                        ev_n.code = code_in;
                    end
                endcase
            end else begin
                unique case (state)
                    S_E0: begin
                        unique case (1'b1)
                            code_in == PS2_F0: state_n = S_E0F0;
                            code_in == PS2_E0: state_n = S_E0;
                            code_in == PS2_E1: begin
                                state_n = S_PAUSE;
                                cnt_n   = 3'd1;
                            end
                            default: begin
                                emit      = 1'b1;
                                ev_n.code = code_in;
                                ev_n.ext  = 1'b1;
                                state_n   = S_IDLE;
                            end
                        endcase
                    end
                    S_F0, S_E0F0: begin
                        emit      = 1'b1;
                        ev_n.code = code_in;
                        ev_n.rel  = 1'b1;
                        ev_n.ext  = (state == S_E0F0);
                        state_n   = S_IDLE;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end else if ((state != S_IDLE) && (timer == T_LAST)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            seq_err <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || code_strobe || code_err || (state == S_IDLE)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Extended 12/59 are the synthetic shifts some keyboards wrap around nav keys.
    assign fake = DROP_FAKE_SHIFT && ev_n.ext &&
                  ((ev_n.code == FAKE_LSHIFT) || (ev_n.code == FAKE_RSHIFT));
    assign push = emit && !fake;
    assign pop  = ev_valid && ev_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ev_n),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign head_ev     = key_ev_t'(head);
    assign ev_valid    = !empty;
    assign ev_code     = head_ev.code;
    assign ev_extended = head_ev.ext;
    assign ev_release  = head_ev.rel;
    assign ev_pause    = head_ev.pause;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: vector table of byte sequences plus
// hand-written sequences for hold, error, timeout, overflow and reset cases.
module tb_ps2_key_event;

    localparam int DEPTH = 8;
    localparam int TOUT  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code_in = '0;
    logic       code_strobe = 1'b0;
    logic       code_err = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_extended;
    logic       ev_release;
    logic       ev_pause;
    logic       seq_err;
    logic       overflow;
    logic [3:0] fifo_level;

    int total = 0;
    int bad = 0;
    logic err_seen;

    ps2_key_event #(
        .DEPTH           (DEPTH),
        .TIMEOUT_CYC     (TOUT),
        .DROP_FAKE_SHIFT (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .code_in     (code_in),
        .code_strobe (code_strobe),
        .code_err    (code_err),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_extended (ev_extended),
        .ev_release  (ev_release),
        .ev_pause    (ev_pause),
        .seq_err     (seq_err),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [63:0] b;
        logic        has_ev;
        logic [10:0] ev;
        logic        err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        code_in     = b;
        code_strobe = 1'b1;
        @(negedge clk);
        code_strobe = 1'b0;
        if (seq_err) err_seen = 1'b1;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] c, input logic e, r, p);
        return {p, r, e, c};
    endfunction

    function automatic logic [10:0] head();
        return {ev_pause, ev_release, ev_extended, ev_code};
    endfunction

    logic [7:0] drain_exp [8];
    int hit;

    initial begin
        vecs[0]  = '{"make",      1, 64'h1C,               1, mk(8'h1C,0,0,0), 0};
        vecs[1]  = '{"break",     2, 64'hF01C,             1, mk(8'h1C,0,1,0), 0};
        vecs[2]  = '{"ext",       2, 64'hE075,             1, mk(8'h75,1,0,0), 0};
        vecs[3]  = '{"ext_brk",   3, 64'hE0F075,           1, mk(8'h75,1,1,0), 0};
        vecs[4]  = '{"pause",     8, 64'hE11477E1F014F077, 1, mk(8'h00,0,0,1), 0};
        vecs[5]  = '{"fake12",    2, 64'hE012,             0, '0,              0};
        vecs[6]  = '{"fake59",    3, 64'hE0F059,           0, '0,              0};
        vecs[7]  = '{"hk_fa",     1, 64'hFA,               0, '0,              0};
        vecs[8]  = '{"hk_aa",     1, 64'hAA,               0, '0,              0};
        vecs[9]  = '{"ovr_00",    1, 64'h00,               0, '0,              1};
        vecs[10] = '{"bad_pfx",   3, 64'hF0E075,           1, mk(8'h75,1,0,0), 1};
        vecs[11] = '{"e0e0",      3, 64'hE0E074,           1, mk(8'h74,1,0,0), 0};
        vecs[12] = '{"e0_ff",     2, 64'hE0FF,             0, '0,              1};
        vecs[13] = '{"plain12",   1, 64'h12,               1, mk(8'h12,0,0,0), 0};
        vecs[14] = '{"e0f0_aa",   3, 64'hE0F0AA,           0, '0,              0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_head", 32'(head()), 0);
        chk("rst_err", 32'(seq_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(fifo_level), 0);

        foreach (vecs[v]) begin
            err_seen = 1'b0;
            for (int i = 0; i < vecs[v].n; i++) begin
                send(vecs[v].b[8*(vecs[v].n-1-i) +: 8]);
                if (i < vecs[v].n - 1)
                    chk({vecs[v].name, "_early"}, 32'(ev_valid), 0);
            end
            chk({vecs[v].name, "_valid"}, 32'(ev_valid), 32'(vecs[v].has_ev));
            if (vecs[v].has_ev)
                chk({vecs[v].name, "_ev"}, 32'(head()), 32'(vecs[v].ev));
            chk({vecs[v].name, "_seqerr"}, 32'(err_seen), 32'(vecs[v].err));
            if (ev_valid) pop_one();
            chk({vecs[v].name, "_level"}, 32'(fifo_level), 0);
        end

        send(8'h1C);
        send(8'h2D);
        repeat (3) @(negedge clk);
        chk("hold_head", 32'(head()), 32'(mk(8'h1C,0,0,0)));
        chk("hold_level", 32'(fifo_level), 2);
        pop_one();
        chk("hold_next", 32'(head()), 32'(mk(8'h2D,0,0,0)));
        chk("hold_level1", 32'(fifo_level), 1);
        pop_one();
        chk("hold_empty", 32'(ev_valid), 0);

        send(8'hE0);
        code_err = 1'b1;
        @(negedge clk);
        code_err = 1'b0;
        chk("cerr_pulse", 32'(seq_err), 1);
        @(negedge clk);
        chk("cerr_pulse_end", 32'(seq_err), 0);
        send(8'h6B);
        chk("cerr_ev", 32'(head()), 32'(mk(8'h6B,0,0,0)));
        chk("cerr_level", 32'(fifo_level), 1);
        pop_one();

        send(8'hE0);
        hit = TOUT + 6;
        for (int i = 1; i <= TOUT + 5; i++) begin
            @(negedge clk);
            if (seq_err) begin
                hit = i;
                break;
            end
        end
        chk("tout_cycle", 32'(hit), 32'(TOUT));
        send(8'h74);
        chk("tout_ev", 32'(head()), 32'(mk(8'h74,0,0,0)));
        pop_one();

        for (int i = 0; i < 8; i++) send(8'h15 + 8'(i));
        chk("fill_level", 32'(fifo_level), 8);
        chk("fill_ovf", 32'(overflow), 0);
        send(8'h1D);
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head", 32'(ev_code), 32'h15);
        ev_ready = 1'b1;
        send(8'h1E);
        ev_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 8);
        chk("pp_ovf", 32'(overflow), 1);
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'h16 + 8'(i);
        drain_exp[7] = 8'h1E;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(ev_code), 32'(drain_exp[i]));
            pop_one();
        end
        chk("drain_empty", 32'(ev_valid), 0);

        send(8'h1C);
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        @(negedge clk);
        chk("rst_mid_valid", 32'(ev_valid), 0);
        chk("rst_mid_head", 32'(head()), 0);
        chk("rst_mid_level", 32'(fifo_level), 0);
        chk("rst_mid_ovf", 32'(overflow), 0);
        chk("rst_mid_err", 32'(seq_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
